// File: rtl/ddr_test_sequencer.sv
// DDR traffic test sequencer: waits for stable calibration, then drives write and read-back
// passes on the traffic generator while tracking miscompares, hung phases and calibration loss.
module ddr_test_sequencer #(
    parameter int ADDR_W      = 28,
    parameter int BASE_ADDR   = 0,
    parameter int TEST_LEN    = 4096,
    parameter int NUM_PASSES  = 0,
    parameter int CAL_STABLE  = 16,
    parameter int TIMEOUT_CYC = 1 << 20,
    parameter int AUTO_START  = 1,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              start_i,
    input  logic              clear_i,
    output logic              gen_start_o,
    output logic              gen_mode_o,
    output logic [ADDR_W-1:0] gen_base_o,
    output logic [ADDR_W-1:0] gen_len_o,
    output logic [15:0]       gen_seed_o,
    input  logic              gen_done_i,
    input  logic              gen_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              timeout_o,
    output logic              calib_lost_o,
    output logic [15:0]       pass_cnt_o,
    output logic [15:0]       err_cnt_o
);

    localparam int TMR_W = 25;
    localparam int CAL_W = $clog2(CAL_STABLE + 1);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_STABLE - 1);
    localparam logic [TMR_W-1:0] TMO_LIM  = TMR_W'(TIMEOUT_CYC);
    localparam logic [15:0]      PASS_LIM = 16'(NUM_PASSES);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_CAL = 4'd1,
        S_WR_GO    = 4'd2,
        S_WR_BUSY  = 4'd3,
        S_RD_GO    = 4'd4,
        S_RD_BUSY  = 4'd5,
        S_PASS_END = 4'd6,
        S_DONE     = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CAL_W-1:0]   r_cal_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_inc;
    logic [15:0]        r_pass_cnt;
    logic [15:0]        r_err_cnt;
    logic [15:0]        w_pass_inc;
    logic               r_error;
    logic               r_timeout;
    logic               r_calib_lost;
    logic               r_gen_start;
    logic               r_gen_mode;
    logic               r_busy;
    logic               r_done;
    logic               w_gen_start_nxt;
    logic               w_gen_mode_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_in_run;
    logic               w_busy_phase;
    logic               w_calib_loss;
    logic               w_tmo_hit;
    logic               w_err_hit;
    logic               w_last_pass;

    assign w_in_run     = (r_state == S_WR_GO)   || (r_state == S_WR_BUSY) ||
                          (r_state == S_RD_GO)   || (r_state == S_RD_BUSY) ||
                          (r_state == S_PASS_END);
    assign w_busy_phase = (r_state == S_WR_BUSY) || (r_state == S_RD_BUSY);
    assign w_calib_loss = w_in_run && !init_calib_complete;
    assign w_timer_inc  = r_timer + 25'd1;
    // A completing phase beats the timer in the same cycle; calib loss takes precedence.
    assign w_tmo_hit    = w_busy_phase && !gen_done_i && !w_calib_loss && (w_timer_inc >= TMO_LIM);
    assign w_err_hit    = (r_state == S_RD_BUSY) && gen_err_i;
    assign w_pass_inc   = sat_inc16(r_pass_cnt);
    assign w_last_pass  = (NUM_PASSES != 0) && (w_pass_inc == PASS_LIM);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; clear wins over everything, then calibration loss.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end else if (w_calib_loss) begin
            w_state_nxt = S_FAIL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i || (AUTO_START != 0)) begin
                        w_state_nxt = S_WAIT_CAL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT_CAL: begin
                    if (init_calib_complete && (r_cal_cnt == CAL_LAST)) begin
                        w_state_nxt = S_WR_GO;
                    end else begin
                        w_state_nxt = S_WAIT_CAL;
                    end
                end
                S_WR_GO: w_state_nxt = S_WR_BUSY;
                S_WR_BUSY: begin
                    if (gen_done_i) begin
                        w_state_nxt = S_RD_GO;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_state_nxt = S_WR_BUSY;
                    end
                end
                S_RD_GO: w_state_nxt = S_RD_BUSY;
                S_RD_BUSY: begin
                    if (w_err_hit && (STOP_ON_ERR != 0)) begin
                        w_state_nxt = S_FAIL;
                    end else if (gen_done_i) begin
                        w_state_nxt = S_PASS_END;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_state_nxt = S_RD_BUSY;
                    end
                end
                S_PASS_END: begin
                    if (w_last_pass) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WR_GO;
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                S_FAIL:  w_state_nxt = S_FAIL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State-derived output decode, registered below so it trails the state by one cycle.
    always_comb begin
        w_gen_start_nxt = 1'b0;
        w_gen_mode_nxt  = r_gen_mode;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE:     w_busy_nxt = 1'b0;
            S_WAIT_CAL: w_busy_nxt = 1'b1;
            S_WR_GO: begin
                w_gen_start_nxt = 1'b1;
                w_gen_mode_nxt  = 1'b0;
                w_busy_nxt      = 1'b1;
            end
            S_WR_BUSY:  w_busy_nxt = 1'b1;
            S_RD_GO: begin
                w_gen_start_nxt = 1'b1;
                w_gen_mode_nxt  = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            S_RD_BUSY:  w_busy_nxt = 1'b1;
            S_PASS_END: w_busy_nxt = 1'b1;
            S_DONE:     w_done_nxt = 1'b1;
            S_FAIL:     w_done_nxt = 1'b0;
            default:    w_busy_nxt = 1'b0;
        endcase
    end

    // Output registers for the state-derived strobes and levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_start <= 1'b0;
            r_gen_mode  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_gen_start <= w_gen_start_nxt;
            r_gen_mode  <= w_gen_mode_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Counters, phase timer and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cal_cnt    <= '0;
            r_timer      <= '0;
            r_pass_cnt   <= 16'd0;
            r_err_cnt    <= 16'd0;
            r_error      <= 1'b0;
            r_timeout    <= 1'b0;
            r_calib_lost <= 1'b0;
        end else if (clear_i) begin
            r_cal_cnt    <= '0;
            r_timer      <= '0;
            r_pass_cnt   <= 16'd0;
            r_err_cnt    <= 16'd0;
            r_error      <= 1'b0;
            r_timeout    <= 1'b0;
            r_calib_lost <= 1'b0;
        end else begin
            if ((r_state == S_WAIT_CAL) && init_calib_complete) begin
                r_cal_cnt <= r_cal_cnt + 1'b1;
            end else begin
                r_cal_cnt <= '0;
            end

            if ((r_state == S_WR_GO) || (r_state == S_RD_GO)) begin
                r_timer <= '0;
            end else if (w_busy_phase) begin
                r_timer <= w_timer_inc;
            end else begin
                r_timer <= r_timer;
            end

            if ((r_state == S_PASS_END) && !w_calib_loss) begin
                r_pass_cnt <= w_pass_inc;
            end else begin
                r_pass_cnt <= r_pass_cnt;
            end

            if (w_err_hit) begin
                r_err_cnt <= sat_inc16(r_err_cnt);
            end else begin
                r_err_cnt <= r_err_cnt;
            end

            r_error      <= r_error | w_err_hit | w_tmo_hit | w_calib_loss;
            r_timeout    <= r_timeout | w_tmo_hit;
            r_calib_lost <= r_calib_lost | w_calib_loss;
        end
    end

    assign gen_start_o  = r_gen_start;
    assign gen_mode_o   = r_gen_mode;
    assign gen_base_o   = ADDR_W'(BASE_ADDR);
    assign gen_len_o    = ADDR_W'(TEST_LEN);
    assign gen_seed_o   = r_pass_cnt;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign timeout_o    = r_timeout;
    assign calib_lost_o = r_calib_lost;
    assign pass_cnt_o   = r_pass_cnt;
    assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Directed bench for ddr_test_sequencer: three configurations covering calibration wait,
// multi-pass completion, error counting, timeout, calibration loss, clear and saturation.
module tb_ddr_test_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic rst_n, b_rst_n;
    logic a_calib, a_start, a_clear, a_gen_done, a_gen_err;
    logic b_calib, b_start, b_clear, b_gen_done, b_gen_err;
    logic c_calib, c_start, c_clear, c_gen_done, c_gen_err;
    logic a_gen_start, a_gen_mode, a_busy, a_done, a_error, a_timeout, a_calib_lost;
    logic b_gen_start, b_gen_mode, b_busy, b_done, b_error, b_timeout, b_calib_lost;
    logic c_gen_start, c_gen_mode, c_busy, c_done, c_error, c_timeout, c_calib_lost;
    logic [27:0] a_gen_base, a_gen_len, b_gen_base, b_gen_len, c_gen_base, c_gen_len;
    logic [15:0] a_gen_seed, a_pass_cnt, a_err_cnt;
    logic [15:0] b_gen_seed, b_pass_cnt, b_err_cnt;
    logic [15:0] c_gen_seed, c_pass_cnt, c_err_cnt;

    // A: short timeout, runs forever, keeps going on errors.
    ddr_test_sequencer #(.ADDR_W(28), .BASE_ADDR(256), .TEST_LEN(64), .NUM_PASSES(0),
        .CAL_STABLE(4), .TIMEOUT_CYC(50), .AUTO_START(1), .STOP_ON_ERR(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(a_calib), .start_i(a_start),
        .clear_i(a_clear), .gen_start_o(a_gen_start), .gen_mode_o(a_gen_mode),
        .gen_base_o(a_gen_base), .gen_len_o(a_gen_len), .gen_seed_o(a_gen_seed),
        .gen_done_i(a_gen_done), .gen_err_i(a_gen_err), .busy_o(a_busy), .done_o(a_done),
        .error_o(a_error), .timeout_o(a_timeout), .calib_lost_o(a_calib_lost),
        .pass_cnt_o(a_pass_cnt), .err_cnt_o(a_err_cnt));

    // B: three passes, long timeout.
    ddr_test_sequencer #(.ADDR_W(28), .BASE_ADDR(0), .TEST_LEN(4096), .NUM_PASSES(3),
        .CAL_STABLE(16), .TIMEOUT_CYC(1 << 20), .AUTO_START(1), .STOP_ON_ERR(0)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .init_calib_complete(b_calib), .start_i(b_start),
        .clear_i(b_clear), .gen_start_o(b_gen_start), .gen_mode_o(b_gen_mode),
        .gen_base_o(b_gen_base), .gen_len_o(b_gen_len), .gen_seed_o(b_gen_seed),
        .gen_done_i(b_gen_done), .gen_err_i(b_gen_err), .busy_o(b_busy), .done_o(b_done),
        .error_o(b_error), .timeout_o(b_timeout), .calib_lost_o(b_calib_lost),
        .pass_cnt_o(b_pass_cnt), .err_cnt_o(b_err_cnt));

    // C: manual start, stop on first error.
    ddr_test_sequencer #(.ADDR_W(28), .BASE_ADDR(4096), .TEST_LEN(8), .NUM_PASSES(0),
        .CAL_STABLE(2), .TIMEOUT_CYC(1000), .AUTO_START(0), .STOP_ON_ERR(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(c_calib), .start_i(c_start),
        .clear_i(c_clear), .gen_start_o(c_gen_start), .gen_mode_o(c_gen_mode),
        .gen_base_o(c_gen_base), .gen_len_o(c_gen_len), .gen_seed_o(c_gen_seed),
        .gen_done_i(c_gen_done), .gen_err_i(c_gen_err), .busy_o(c_busy), .done_o(c_done),
        .error_o(c_error), .timeout_o(c_timeout), .calib_lost_o(c_calib_lost),
        .pass_cnt_o(c_pass_cnt), .err_cnt_o(c_err_cnt));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic strobe(input int which);
        case (which)
            0:       return a_gen_start;
            1:       return b_gen_start;
            default: return c_gen_start;
        endcase
    endfunction

    // Waits (bounded) for the selected instance's gen_start_o pulse.
    task automatic wait_start(input string tag, input int which, input int budget);
        int n;
        n = 0;
        while (strobe(which) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(strobe(which)), 32'd1);
    endtask

    initial begin
        int        n_seen;
        int        starts;
        int        ph;
        logic [5:0] modes;

        rst_n = 1'b0; b_rst_n = 1'b0;
        {a_calib, a_start, a_clear, a_gen_done, a_gen_err} = 5'b0;
        {b_calib, b_start, b_clear, b_gen_done, b_gen_err} = 5'b0;
        {c_calib, c_start, c_clear, c_gen_done, c_gen_err} = 5'b10000;

        #12;
        check_eq("rst_a_flags", 32'({a_gen_start, a_gen_mode, a_busy, a_done, a_error,
                 a_timeout, a_calib_lost}), 32'd0);
        check_eq("rst_a_cnts", {a_pass_cnt, a_err_cnt}, 32'd0);
        check_eq("rst_b_flags", 32'({b_gen_start, b_busy, b_done, b_error}), 32'd0);
        check_eq("rst_c_flags", 32'({c_gen_start, c_busy, c_done, c_error}), 32'd0);
        check_eq("a_base", 32'(a_gen_base), 32'd256);
        check_eq("a_len", 32'(a_gen_len), 32'd64);
        check_eq("b_base", 32'(b_gen_base), 32'd0);
        check_eq("b_len", 32'(b_gen_len), 32'd4096);
        check_eq("c_base_len", {4'd0, c_gen_base[13:0], c_gen_len[13:0]}, {4'd0, 14'd4096, 14'd8});
        #10;
        rst_n = 1'b1; b_rst_n = 1'b1;

        // A leaves IDLE on its own; busy_o follows one cycle after WAIT_CAL is entered.
        tick(); tick();
        check_eq("a_busy_waitcal", 32'(a_busy), 32'd1);
        check_eq("c_idle_nostart", 32'(c_busy), 32'd0);

        a_calib = 1'b1;
        wait_start("a_wr_start", 0, 20);
        check_eq("a_wr_mode", 32'(a_gen_mode), 32'd0);
        check_eq("a_seed0", 32'(a_gen_seed), 32'd0);

        // Write phase: errors are ignored; done lands on busy cycle 50, beating the timeout.
        for (int k = 1; k <= 50; k++) begin
            a_gen_done = (k == 50);
            a_gen_err  = (k == 3) || (k == 7);
            tick();
        end
        a_gen_done = 1'b0; a_gen_err = 1'b0;
        check_eq("a_no_timeout_at_50", 32'(a_timeout), 32'd0);
        check_eq("a_wr_err_ignored", 32'(a_err_cnt), 32'd0);
        check_eq("a_err_flag_clean", 32'(a_error), 32'd0);

        wait_start("a_rd_start", 0, 5);
        check_eq("a_rd_mode", 32'(a_gen_mode), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            a_gen_err  = (k % 2 == 0) && (k <= 10);
            a_gen_done = (k == 12);
            tick();
        end
        a_gen_done = 1'b0; a_gen_err = 1'b0;
        check_eq("a_err_cnt5", 32'(a_err_cnt), 32'd5);
        check_eq("a_error_set", 32'(a_error), 32'd1);

        wait_start("a_pass2_start", 0, 5);
        check_eq("a_pass_cnt1", 32'(a_pass_cnt), 32'd1);
        check_eq("a_seed1", 32'(a_gen_seed), 32'd1);
        check_eq("a_pass2_mode", 32'(a_gen_mode), 32'd0);

        // No done: the 50th busy cycle times out.
        for (int k = 1; k <= 49; k++) tick();
        check_eq("a_timeout_early", 32'(a_timeout), 32'd0);
        tick();
        check_eq("a_timeout_set", 32'(a_timeout), 32'd1);
        tick();
        check_eq("a_fail_not_busy", 32'({a_busy, a_done}), 32'd0);
        a_gen_done = 1'b1; a_gen_err = 1'b1;
        tick();
        a_gen_done = 1'b0; a_gen_err = 1'b0;
        check_eq("a_fail_holds", {a_pass_cnt, a_err_cnt}, {16'd1, 16'd5});

        // Clear with a simultaneous error pulse: the error is dropped.
        a_clear = 1'b1; a_gen_err = 1'b1;
        tick();
        a_clear = 1'b0; a_gen_err = 1'b0;
        check_eq("a_clear_cnts", {a_pass_cnt, a_err_cnt}, 32'd0);
        check_eq("a_clear_flags", 32'({a_error, a_timeout, a_calib_lost}), 32'd0);

        wait_start("a_restart_wr", 0, 20);
        a_gen_done = 1'b1;
        tick();
        a_gen_done = 1'b0;
        wait_start("a_restart_rd", 0, 5);
        a_calib = 1'b0;
        tick();
        check_eq("a_calib_lost", 32'({a_calib_lost, a_error, a_timeout}), 32'b110);
        tick();
        check_eq("a_calib_fail_idle", 32'(a_busy), 32'd0);
        a_calib = 1'b1; a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check_eq("a_clear2_flags", 32'({a_calib_lost, a_error}), 32'd0);
        wait_start("a_restart_after_clear", 0, 20);

        // C: manual start, first read error stops the sequence.
        check_eq("c_still_idle", 32'(c_busy), 32'd0);
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        wait_start("c_wr_start", 2, 10);
        c_gen_done = 1'b1;
        tick();
        c_gen_done = 1'b0;
        wait_start("c_rd_start", 2, 5);
        c_gen_err = 1'b1;
        tick();
        c_gen_err = 1'b0;
        check_eq("c_err1", {c_err_cnt, 15'd0, c_error}, {16'd1, 16'd1});
        tick();
        check_eq("c_stop_on_err", 32'({c_busy, c_timeout, c_done}), 32'd0);

        // B: calibration glitch at sample 10 restarts the 16-sample stability count.
        for (int i = 1; i <= 9; i++) begin
            b_calib = 1'b1;
            tick();
        end
        b_calib = 1'b0;
        tick();
        b_calib = 1'b1;
        n_seen = 0;
        for (int n = 1; n <= 40 && n_seen == 0; n++) begin
            tick();
            if (b_gen_start === 1'b1) n_seen = n;
        end
        // 16th high sample moves to WR_GO; the registered strobe shows on the next edge.
        check_eq("b_cal_latency", 32'(n_seen), 32'd17);

        starts = 1;
        modes  = {5'd0, b_gen_mode};
        ph     = 0;
        for (int n = 0; n < 2000 && b_done !== 1'b1; n++) begin
            ph++;
            b_gen_done = (ph == 100);
            tick();
            b_gen_done = 1'b0;
            if (b_gen_start === 1'b1) begin
                starts++;
                modes = {modes[4:0], b_gen_mode};
                ph = 0;
            end
        end
        check_eq("b_starts", 32'(starts), 32'd6);
        check_eq("b_modes", 32'(modes), 32'b010101);
        check_eq("b_pass_cnt3", 32'(b_pass_cnt), 32'd3);
        check_eq("b_done_noerr", 32'({b_done, b_error, b_busy}), 32'b100);
        check_eq("b_seed3", 32'(b_gen_seed), 32'd3);

        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        tick();
        check_eq("b_clear_done", {15'd0, b_done, b_pass_cnt}, 32'd0);
        wait_start("b_sat_wr", 1, 40);
        b_gen_done = 1'b1;
        tick();
        b_gen_done = 1'b0;
        wait_start("b_sat_rd", 1, 5);
        b_gen_err = 1'b1;
        for (int k = 0; k < 65534; k++) tick();
        check_eq("b_err_fffe", 32'(b_err_cnt), 32'h0000FFFE);
        for (int k = 0; k < 6; k++) tick();
        b_gen_err = 1'b0;
        check_eq("b_err_sat", 32'(b_err_cnt), 32'h0000FFFF);
        check_eq("b_sat_flags", 32'({b_error, b_timeout}), 32'b10);
        b_gen_done = 1'b1;
        tick();
        b_gen_done = 1'b0;
        wait_start("b_after_sat", 1, 5);
        check_eq("b_pass_after_sat", 32'(b_pass_cnt), 32'd1);

        // Asynchronous reset mid-pass clears outputs without waiting for a clock edge.
        #1 b_rst_n = 1'b0;
        #1;
        check_eq("b_async_flags", 32'({b_gen_start, b_gen_mode, b_busy, b_done, b_error}), 32'd0);
        check_eq("b_async_cnts", {b_pass_cnt, b_err_cnt}, 32'd0);
        check_eq("b_async_seed", 32'(b_gen_seed), 32'd0);
        #2 b_rst_n = 1'b1;
        tick(); tick();
        check_eq("b_restart_busy", 32'(b_busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
